// File: rtl/spi_slave.sv
// SPI mode 3 responder: synchronises ss/sck/mosi into clk and moves bytes both ways.
// Optional SPI_SLAVE_OVERRUN_EN adds rack/ovr to hold rdata until consumed.
module spi_slave #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b1
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       mlb,
  input  logic       ss,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tdat,
  output logic       tx_ack,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       abort,
  output logic       busy
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  input  logic       rack,
  output logic       ovr
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] ss_sq, sck_sq, mosi_sq;
  logic ss_pq, sck_pq;
  logic ss_s, sck_s, mosi_s;
  logic ss_fall, ss_rise, sck_fall, sck_rise;

  // ss resets low so a frame already running at reset release is never joined
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ss_sq   <= '0;
      sck_sq  <= '1;
      mosi_sq <= '1;
      ss_pq   <= 1'b0;
      sck_pq  <= 1'b1;
    end else begin
      ss_sq   <= {ss_sq[SYNC_STAGES-2:0], ss};
      sck_sq  <= {sck_sq[SYNC_STAGES-2:0], sck};
      mosi_sq <= {mosi_sq[SYNC_STAGES-2:0], mosi};
      ss_pq   <= ss_s;
      sck_pq  <= sck_s;
    end
  end

  assign ss_s     = ss_sq[SYNC_STAGES-1];
  assign sck_s    = sck_sq[SYNC_STAGES-1];
  assign mosi_s   = mosi_sq[SYNC_STAGES-1];
  assign ss_fall  = ss_pq & ~ss_s;
  assign ss_rise  = ~ss_pq & ss_s;
  assign sck_fall = sck_pq & ~sck_s;
  assign sck_rise = ~sck_pq & sck_s;

  state_t     state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic       first_q, first_d;
  logic       mlb_q, mlb_d;
  logic [7:0] treg_q, treg_d;
  logic [7:0] rreg_q, rreg_d;
  logic [7:0] rdata_q, rdata_d;
  logic       miso_q, miso_d;
  logic       rvalid_q, rvalid_d;
  logic       tx_ack_q, tx_ack_d;
  logic       abort_q, abort_d;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       held_q, held_d;
  logic       ovr_q, ovr_d;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= IDLE;
      bitcnt_q <= 4'd0;
      first_q  <= 1'b0;
      mlb_q    <= 1'b0;
      treg_q   <= 8'hFF;
      rreg_q   <= 8'hFF;
      rdata_q  <= 8'hFF;
      miso_q   <= IDLE_MISO;
      rvalid_q <= 1'b0;
      tx_ack_q <= 1'b0;
      abort_q  <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
      held_q   <= 1'b0;
      ovr_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      first_q  <= first_d;
      mlb_q    <= mlb_d;
      treg_q   <= treg_d;
      rreg_q   <= rreg_d;
      rdata_q  <= rdata_d;
      miso_q   <= miso_d;
      rvalid_q <= rvalid_d;
      tx_ack_q <= tx_ack_d;
      abort_q  <= abort_d;
`ifdef SPI_SLAVE_OVERRUN_EN
      held_q   <= held_d;
      ovr_q    <= ovr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    first_d  = first_q;
    mlb_d    = mlb_q;
    treg_d   = treg_q;
    rreg_d   = rreg_q;
    rdata_d  = rdata_q;
    miso_d   = miso_q;
    rvalid_d = 1'b0;
    tx_ack_d = 1'b0;
    abort_d  = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
    held_d   = held_q & ~rack;
    ovr_d    = ovr_q & ~rack;
`endif
    unique case (state_q)
      IDLE: begin
        miso_d = IDLE_MISO;
        if (ss_fall) begin
          treg_d   = tdat;
          tx_ack_d = 1'b1;
          mlb_d    = mlb;
          bitcnt_d = 4'd0;
          first_d  = 1'b1;
          state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (bitcnt_q == 4'd8) begin
          // completion beats a coincident ss_rise: no abort
          bitcnt_d = 4'd0;
          treg_d   = tdat;
          tx_ack_d = 1'b1;
          first_d  = 1'b1;
`ifdef SPI_SLAVE_OVERRUN_EN
          if (held_q && !rack) begin
            ovr_d = 1'b1;
          end else begin
            rdata_d  = rreg_q;
            rvalid_d = 1'b1;
            held_d   = 1'b1;
          end
`else
          rdata_d  = rreg_q;
          rvalid_d = 1'b1;
`endif
          if (ss_rise) begin
            state_d = IDLE;
            miso_d  = IDLE_MISO;
          end
        end else if (ss_rise) begin
          state_d = IDLE;
          miso_d  = IDLE_MISO;
          abort_d = (bitcnt_q != 4'd0);
        end else begin
          if (sck_fall) begin
            if (first_q) begin
              miso_d  = mlb_q ? treg_q[7] : treg_q[0];
              first_d = 1'b0;
            end else if (mlb_q) begin
              treg_d = {treg_q[6:0], 1'b1};
              miso_d = treg_q[6];
            end else begin
              treg_d = {1'b1, treg_q[7:1]};
              miso_d = treg_q[1];
            end
          end
          if (sck_rise) begin
            rreg_d   = mlb_q ? {rreg_q[6:0], mosi_s}
                             : {mosi_s, rreg_q[7:1]};
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
      end
    endcase
  end

  assign miso   = miso_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign tx_ack = tx_ack_q;
  assign abort  = abort_q;
  assign busy   = (state_q == ACTIVE);
`ifdef SPI_SLAVE_OVERRUN_EN
  assign ovr    = ovr_q;
`endif

endmodule
